// File: rtl/counter4_sequencer.sv
// Command-driven controller for a loadable up/down counter: accepts LOAD, UP N,
// DOWN N and SEEK commands over valid/ready and pulses done with the final value.
module counter4_sequencer #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] cnt_data,
    output logic             cnt_up_down,
    output logic             cnt_enable,
    output logic             cnt_load,
    input  logic [WIDTH-1:0] cnt_result,
    input  logic             cnt_terminal_count,
    output logic             done,
    output logic [WIDTH-1:0] done_value,
    output logic             error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_SEEK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic             error_q, error_d;

    // Next-state logic: command capture, step/cycle counting and termination.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        step_d  = step_q;
        cyc_d   = cyc_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    error_d = 1'b0;
                    cyc_d   = {CW{1'b0}};
                    case (cmd_op)
                        OP_LOAD: state_d = ST_LOAD;
                        OP_UP, OP_DOWN: begin
                            step_d = cmd_data;
                            if (cmd_data == {WIDTH{1'b0}}) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                        OP_SEEK: state_d = ST_RUN;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_DONE;
            ST_RUN: begin
                if (op_q == OP_SEEK) begin
                    // Terminal count wins over timeout when both happen together.
                    if (cnt_terminal_count) begin
                        state_d = ST_DONE;
                    end else if (cyc_q == CW'(TIMEOUT - 1)) begin
                        state_d = ST_DONE;
                        error_d = 1'b1;
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end else begin
                    step_d = step_q - WIDTH'(1);
                    if (step_q == WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and command registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= 2'b00;
            data_q  <= {WIDTH{1'b0}};
            step_q  <= {WIDTH{1'b0}};
            cyc_q   <= {CW{1'b0}};
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            step_q  <= step_d;
            cyc_q   <= cyc_d;
            error_q <= error_d;
        end
    end

    // Output decode; reset held low forces every output to zero immediately.
    always_comb begin
        cmd_ready   = 1'b0;
        cnt_data    = {WIDTH{1'b0}};
        cnt_up_down = 1'b0;
        cnt_enable  = 1'b0;
        cnt_load    = 1'b0;
        done        = 1'b0;
        done_value  = {WIDTH{1'b0}};
        error       = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IDLE: cmd_ready = 1'b1;
                ST_LOAD: begin
                    cnt_enable = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_data   = data_q;
                end
                ST_RUN: begin
                    if (op_q == OP_SEEK) begin
                        cnt_up_down = 1'b1;
                        cnt_enable  = ~cnt_terminal_count;
                    end else begin
                        cnt_up_down = (op_q == OP_UP);
                        cnt_enable  = 1'b1;
                    end
                end
                ST_DONE: begin
                    done       = 1'b1;
                    done_value = cnt_result;
                    error      = error_q;
                end
                default: cmd_ready = 1'b0;
            endcase
        end else begin
            cmd_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_counter4_sequencer.sv
// Directed bench: drives counter4_sequencer against a behavioural 4-bit counter
// and checks latency, step counts, final values, timeout and mid-run reset.
module tb_counter4_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cnt_data;
    logic       cnt_up_down;
    logic       cnt_enable;
    logic       cnt_load;
    logic [3:0] cnt_result;
    logic       cnt_terminal_count;
    logic       done;
    logic [3:0] done_value;
    logic       error;

    logic [3:0] cnt_val = 4'd0;
    logic       force_tc_low = 1'b0;
    int         en_total = 0, load_total = 0, up_total = 0, done_total = 0;
    int         n_checks = 0, n_errors = 0;

    counter4_sequencer #(.WIDTH(4), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cnt_data(cnt_data), .cnt_up_down(cnt_up_down), .cnt_enable(cnt_enable), .cnt_load(cnt_load),
        .cnt_result(cnt_result), .cnt_terminal_count(cnt_terminal_count),
        .done(done), .done_value(done_value), .error(error)
    );

    always #5 clock = ~clock;

    assign cnt_result         = cnt_val;
    assign cnt_terminal_count = (cnt_val == 4'hF) && !force_tc_low;

    // Behavioural counter plus activity tallies.
    always @(posedge clock) begin
        if (cnt_enable) begin
            if (cnt_load)         cnt_val <= cnt_data;
            else if (cnt_up_down) cnt_val <= cnt_val + 4'd1;
            else                  cnt_val <= cnt_val - 4'd1;
        end
        if (cnt_enable)               en_total   <= en_total + 1;
        if (cnt_enable && cnt_load)   load_total <= load_total + 1;
        if (cnt_enable && cnt_up_down && !cnt_load) up_total <= up_total + 1;
        if (done)                     done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command, wait (bounded) for done and check latency, value, error and activity.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                           input bit hold_valid, input int exp_cycles, input logic [3:0] exp_val,
                           input logic exp_err, input int exp_en, input int exp_up, input int exp_ld);
        int  en0, up0, ld0, cycles;
        bit  seen;
        logic [3:0] val;
        logic       err;
        @(negedge clock);
        en0 = en_total; up0 = up_total; ld0 = load_total;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        @(posedge clock);
        #1;
        if (hold_valid) begin
            cmd_op = 2'b00; cmd_data = 4'd9;
        end else begin
            cmd_valid = 1'b0;
        end
        seen = 1'b0; cycles = 0; val = 4'd0; err = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                seen = 1'b1; cycles = c; val = done_value; err = error;
            end
        end
        cmd_valid = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
        check({tag, "_value"}, 32'(val), 32'(exp_val));
        check({tag, "_error"}, 32'(err), 32'(exp_err));
        check({tag, "_enables"}, 32'(en_total - en0), 32'(exp_en));
        check({tag, "_up_steps"}, 32'(up_total - up0), 32'(exp_up));
        check({tag, "_loads"}, 32'(load_total - ld0), 32'(exp_ld));
        @(negedge clock);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_error_cleared_out"}, 32'(error), 32'd0);
        check({tag, "_ready_again"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int en0, ld0, dn0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'd0;
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_enable", 32'(cnt_enable), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_value", 32'(done_value), 32'd0);
        reset = 1'b1;
        #1;
        check("idle_ready", 32'(cmd_ready), 32'd1);

        //      tag        op     data  hold cyc val   err  en  up  ld
        run_cmd("load5",   2'b00, 4'd5, 1'b0, 2, 4'd5,  1'b0, 1,  0,  1);
        run_cmd("up3",     2'b01, 4'd3, 1'b1, 4, 4'd8,  1'b0, 3,  3,  0);
        run_cmd("load0",   2'b00, 4'd0, 1'b0, 2, 4'd0,  1'b0, 1,  0,  1);
        run_cmd("down2",   2'b10, 4'd2, 1'b0, 3, 4'd14, 1'b0, 2,  0,  0);
        run_cmd("up0",     2'b01, 4'd0, 1'b0, 1, 4'd14, 1'b0, 0,  0,  0);
        run_cmd("load12",  2'b00, 4'd12,1'b0, 2, 4'd12, 1'b0, 1,  0,  1);
        run_cmd("seek12",  2'b11, 4'd7, 1'b1, 5, 4'd15, 1'b0, 3,  3,  0);
        run_cmd("seek15",  2'b11, 4'd0, 1'b0, 2, 4'd15, 1'b0, 0,  0,  0);
        run_cmd("up1wrap", 2'b01, 4'd1, 1'b0, 2, 4'd0,  1'b0, 1,  1,  0);
        run_cmd("up15",    2'b01, 4'd15,1'b0, 16,4'd15, 1'b0, 15, 15, 0);
        run_cmd("load3",   2'b00, 4'd3, 1'b0, 2, 4'd3,  1'b0, 1,  0,  1);
        force_tc_low = 1'b1;
        run_cmd("seek_to", 2'b11, 4'd0, 1'b0, 17,4'd3,  1'b1, 16, 16, 0);
        force_tc_low = 1'b0;

        // Reset in the middle of UP 10 after four steps, with cmd_valid held high.
        run_cmd("load2",   2'b00, 4'd2, 1'b0, 2, 4'd2,  1'b0, 1,  0,  1);
        @(negedge clock);
        en0 = en_total; ld0 = load_total; dn0 = done_total;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'd10;
        @(posedge clock);
        #1;
        cmd_op = 2'b00; cmd_data = 4'd9;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_enable_gated", 32'(cnt_enable), 32'd0);
        @(negedge clock);
        check("midrst_hold_value", 32'(cnt_result), 32'd6);
        check("midrst_ready_low", 32'(cmd_ready), 32'd0);
        reset = 1'b1; cmd_valid = 1'b0;
        repeat (5) @(negedge clock);
        check("midrst_value_after", 32'(cnt_result), 32'd6);
        check("midrst_enables", 32'(en_total - en0), 32'd4);
        check("midrst_no_load", 32'(load_total - ld0), 32'd0);
        check("midrst_no_done", 32'(done_total - dn0), 32'd0);
        check("midrst_idle_ready", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/counter4_sequencer.md
Name: counter4_sequencer

Overview:
- Command-driven controller for the 4-bit loadable up/down counter (data, up_down, enable, load, result, terminal_count).
- Accepts one command at a time over a valid/ready handshake. Supported commands: load a value, step N times up, step N times down, or seek up to terminal count.
- Drives the counter's control pins and reports completion with the final counter value.
- Sits between the command source (testbench or higher-level FSM) and a single counter instance.

Parameters:
- WIDTH, 4, counter data width; also the width of cmd_data and the step count.
- TIMEOUT, 16, maximum RUN cycles for a SEEK before it is aborted with an error.

Ports:
- clock  input  1  rising-edge clock, shared with the counter
- reset  input  1  synchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 SEEK
- cmd_data  input  WIDTH  LOAD value, or step count N for UP/DOWN; ignored for SEEK
- cnt_data  output  WIDTH  to counter data
- cnt_up_down  output  1  to counter up_down (1 = up)
- cnt_enable  output  1  to counter enable
- cnt_load  output  1  to counter load
- cnt_result  input  WIDTH  from counter result
- cnt_terminal_count  input  1  from counter terminal_count (1 when result is all ones)
- done  output  1  one-cycle completion pulse
- done_value  output  WIDTH  cnt_result while done = 1, otherwise 0
- error  output  1  valid with done; 1 = SEEK timed out

Behaviour:
- Reset (reset == 0 at a clock edge):
  - State goes to IDLE; the op, data and step registers clear.
  - All outputs are 0, including cmd_ready, for as long as reset is held.
  - Reset takes effect in any state, including mid-RUN. No further counter enables follow.
- State machine:
  - States are IDLE, LOAD, RUN and DONE.
  - Controller outputs are decoded combinationally from state and registers (Moore style, plus the SEEK gating below).
- IDLE:
  - cmd_ready = 1; all cnt_* outputs are 0.
  - Acceptance happens on a clock edge where cmd_valid & cmd_ready; cmd_op and cmd_data are captured.
  - LOAD goes to the LOAD state.
  - UP or DOWN with N != 0 goes to RUN with remaining = N.
  - UP or DOWN with N == 0 goes straight to DONE; no enable is ever asserted.
  - SEEK goes to RUN with the cycle counter = 0.
- LOAD:
  - Asserts cnt_enable = 1, cnt_load = 1 and cnt_data = captured value for exactly one cycle.
  - Then goes to DONE.
- RUN, UP/DOWN:
  - cnt_enable = 1, cnt_load = 0, cnt_up_down = (op == UP).
  - remaining decrements every cycle; the transition to DONE happens on the edge where remaining == 1.
  - Exactly N enabled cycles are issued.
- RUN, SEEK:
  - cnt_up_down = 1 and cnt_enable = ~cnt_terminal_count.
  - The transition to DONE (error = 0) happens on the edge where cnt_terminal_count == 1; no step is taken in that cycle.
  - The cycle counter increments each RUN cycle. If it reaches TIMEOUT without terminal count, the state goes to DONE with error = 1.
- DONE:
  - done = 1, done_value = cnt_result (the final value, already settled), cmd_ready = 0. Lasts exactly one cycle, then IDLE.
  - The error register holds until the next acceptance.
- Latency, with acceptance at edge T:
  - LOAD: counter loads at edge T+2; done is high in cycle T+2.
  - UP/DOWN N: done is high in the cycle after the Nth step, i.e. N+1 cycles after acceptance.
  - SEEK from value v: 15−v steps plus one detect cycle, then DONE.
- Arithmetic:
  - The counter wraps modulo 2^WIDTH. UP from 15 gives 0; DOWN from 0 gives 15.
  - The controller never checks for or prevents wrap.
  - A step count of N = 15 is legal.
- Handshake:
  - cmd_ready is low in LOAD, RUN and DONE; cmd_valid in those states is ignored and not queued.
  - The command source must hold cmd_op/cmd_data stable only in the accepting cycle.
- Only one of cnt_load / cnt_up_down stepping is ever active per cycle. cnt_load = 1 only in the LOAD state.

Test Plan:
- Reset low for 2 cycles, then high; LOAD data 5 -> cnt_load high for exactly 1 cycle; done in cycle T+2 with done_value = 5, error = 0.
- From 5, UP N = 3 -> exactly 3 cnt_enable cycles with up_down = 1; done_value = 8.
- From 0, DOWN N = 2 -> wrap, done_value = 14. Then UP N = 0 -> done 1 cycle after acceptance, no enable pulse, done_value = 14.
- LOAD 12, then SEEK -> 3 enabled cycles plus 1 detect cycle; done_value = 15, error = 0. SEEK again from 15 -> zero steps, done after 1 RUN cycle.
- SEEK with cnt_terminal_count tied 0 -> exactly TIMEOUT (16) RUN cycles, then done = 1 with error = 1.
- Assert reset mid-RUN of UP N = 10 after 4 steps -> next cycle state IDLE, cnt_enable = 0, done never pulses, counter holds at start+4; cmd_valid during RUN/DONE is never accepted.
